// File: rtl/fifo_rtl.sv
// Single-clock synchronous FIFO with registered read data and occupancy-derived full/empty flags.
// Define FIFO_RTL_ERR_FLAGS_EN to add the sticky overflow/underflow outputs.
module fifo_rtl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
`ifdef FIFO_RTL_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic w_full;
  logic w_empty;
  logic w_wr_accept;
  logic w_rd_accept;

  // Flags come only from the registered count, so acceptance uses pre-edge state.
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_wr_accept = enable && write_en && !w_full;
  assign w_rd_accept = enable && read_en  && !w_empty;

  // NOTE: storage has no reset; the pointers define what is valid, so the array
  // can map onto plain RAM without a reset network.
  always_ff @(posedge clock) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_accept) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_data_out <= r_mem[r_rd_ptr];
      end
      if (w_wr_accept && !w_rd_accept) begin
        r_count <= r_count + CW'(1);
      end else if (w_rd_accept && !w_wr_accept) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign data_out = r_data_out;
  assign full     = w_full;
  assign empty    = w_empty;

`ifdef FIFO_RTL_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Attempts are flagged even when the paired opposite operation is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (enable && write_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (enable && read_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_fifo_rtl.sv
// Self-checking bench for fifo_rtl: a queue-based FIFO model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fifo_rtl;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 64;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  enable;
  logic                  write_en;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
`ifdef FIFO_RTL_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  fifo_rtl #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .write_en (write_en),
    .read_en  (read_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
`ifdef FIFO_RTL_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: a plain queue of stored words plus the last word read out.
  logic [DATA_WIDTH-1:0] m_q[$];
  logic [DATA_WIDTH-1:0] m_dout;
  bit                    m_ovf;
  bit                    m_udf;

  function automatic void model_step();
    int  n;
    bit  wr_ok;
    bit  rd_ok;
    if (!reset) begin
      m_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else if (enable) begin
      n     = m_q.size();
      wr_ok = write_en && (n < DEPTH);
      rd_ok = read_en && (n > 0);
      if (rd_ok) m_dout = m_q.pop_front();
      if (wr_ok) m_q.push_back(data_in);
      if (write_en && n == DEPTH) m_ovf = 1'b1;
      if (read_en && n == 0)      m_udf = 1'b1;
    end
  endfunction

  always @(posedge clock or negedge reset) model_step();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_on) begin
      check("data_out", 32'(data_out), 32'(m_dout));
      check("full",     32'(full),     32'(m_q.size() == DEPTH));
      check("empty",    32'(empty),    32'(m_q.size() == 0));
`ifdef FIFO_RTL_ERR_FLAGS_EN
      check("overflow",  32'(overflow),  32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_udf));
`endif
    end
  end

  // Apply one cycle of inputs; called at a falling edge, returns at the next one.
  task automatic drive(input logic e, input logic w, input logic r, input logic [DATA_WIDTH-1:0] d);
    enable   = e;
    write_en = w;
    read_en  = r;
    data_in  = d;
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;
    #12;
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_data_out", 32'(data_out), 32'h00);
    @(negedge clock);
    reset  = 1'b1;
    cmp_on = 1'b1;

    // Idle with enable high.
    drive(1, 0, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    check("idle_empty",    32'(empty),    32'd1);
    check("idle_data_out", 32'(data_out), 32'h00);

    // Fill 0x00..0x3F, then a dropped write of 0xAA.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, 0, 8'(i));
      if (i == DEPTH - 2) check("not_full_at_63", 32'(full), 32'd0);
    end
    check("full_after_64", 32'(full), 32'd1);
    drive(1, 1, 0, 8'hAA);
    check("full_after_65", 32'(full), 32'd1);
    check("model_cnt_64",  32'(m_q.size()), 32'd64);
`ifdef FIFO_RTL_ERR_FLAGS_EN
    check("overflow_set", 32'(overflow), 32'd1);
`endif

    // Drain in order, then one read too many.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 1, 8'h00);
      check("drain_data", 32'(data_out), 32'(i));
    end
    check("drained_empty", 32'(empty), 32'd1);
    drive(1, 0, 1, 8'h00);
    check("underread_hold", 32'(data_out), 32'h3F);
`ifdef FIFO_RTL_ERR_FLAGS_EN
    check("underflow_set", 32'(underflow), 32'd1);
`endif

    // Empty with read+write: write wins, read dropped.
    drive(1, 1, 1, 8'h55);
    check("empty_rw_hold", 32'(data_out), 32'h3F);
    check("empty_rw_cnt",  32'(empty),    32'd0);

    // Refill to full, then read+write: read wins, write dropped.
    for (int i = 0; i < DEPTH - 1; i++) drive(1, 1, 0, 8'(8'h80 + i));
    check("refull", 32'(full), 32'd1);
    drive(1, 1, 1, 8'hEE);
    check("full_rw_data", 32'(data_out), 32'h55);
    check("full_rw_full", 32'(full),     32'd0);

    // Drop to half occupancy (32 words: 0x9F..0xBE remain).
    for (int i = 0; i < 31; i++) drive(1, 0, 1, 8'h00);
    check("model_cnt_32", 32'(m_q.size()), 32'd32);

    // Streaming at constant occupancy; output lags input by 32 words.
    for (int i = 0; i < 200; i++) begin
      drive(1, 1, 1, 8'(i));
      check("stream_data", 32'(data_out), (i < 32) ? 32'(8'(8'h9F + i)) : 32'(i - 32));
      check("stream_empty", 32'(empty), 32'd0);
    end
    check("stream_cnt", 32'(m_q.size()), 32'd32);

    // Enable low freezes everything despite requests.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 8'hF0);
      check("freeze_data",  32'(data_out), 32'hA7);
      check("freeze_full",  32'(full),     32'd0);
      check("freeze_empty", 32'(empty),    32'd0);
    end
    drive(1, 1, 1, 8'hF0);
    check("resume_data", 32'(data_out), 32'hA8);

    // Bring occupancy to 10 words.
    for (int i = 0; i < 22; i++) drive(1, 0, 1, 8'h00);
    check("pre_reset_data", 32'(data_out), 32'hBE);
    check("model_cnt_10",   32'(m_q.size()), 32'd10);

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b0;
    #1;
    check("async_empty",    32'(empty),    32'd1);
    check("async_data_out", 32'(data_out), 32'h00);
    @(negedge clock);
    reset = 1'b1;
`ifdef FIFO_RTL_ERR_FLAGS_EN
    check("flags_cleared", 32'({overflow, underflow}), 32'd0);
`endif
    drive(1, 1, 0, 8'hC3);
    check("post_reset_nonempty", 32'(empty), 32'd0);
    drive(1, 0, 1, 8'h00);
    check("post_reset_data",  32'(data_out), 32'hC3);
    check("post_reset_empty", 32'(empty),    32'd1);
    drive(1, 0, 0, 8'h00);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_rtl.md
FIFO_RTL -- requirements
Module: fifo_rtl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter DEPTH, default 64, number of storage words; power of two, at least 2.
REQ-003 Port clock, input, 1 bit, single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 Port enable, input, 1 bit, global operation enable.
REQ-006 Port write_en, input, 1 bit, write request.
REQ-007 Port read_en, input, 1 bit, read request.
REQ-008 Port data_in, input, DATA_WIDTH bits, write data.
REQ-009 Port data_out, output, DATA_WIDTH bits, registered read data.
REQ-010 Port full, output, 1 bit, high when the FIFO holds DEPTH words.
REQ-011 Port empty, output, 1 bit, high when the FIFO holds 0 words.
REQ-012 Port order is clock, reset, enable, write_en, read_en, data_in, data_out, full, empty, then the optional ports of REQ-030.

Function
REQ-013 Storage: DEPTH x DATA_WIDTH memory, write pointer and read pointer of log2(DEPTH) bits each, occupancy counter of log2(DEPTH)+1 bits.
REQ-014 Accepted write: enable=1, write_en=1, full=0 at a rising edge -> mem[wr_ptr] <= data_in, wr_ptr increments.
REQ-015 Accepted read: enable=1, read_en=1, empty=0 at a rising edge -> data_out <= mem[rd_ptr], rd_ptr increments; data_out valid 1 cycle after the read edge.
REQ-016 Pointers wrap modulo DEPTH (DEPTH-1 -> 0) with no other side effect.
REQ-017 Counter: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write or on no operation.
REQ-018 full = (count == DEPTH) and empty = (count == 0), both decoded from registered state with no combinational path from the inputs.
REQ-019 Write while full is ignored: memory, pointers and count are unchanged.
REQ-020 Read while empty is ignored: data_out holds and pointers are unchanged.
REQ-021 When full, read and write together: the read is accepted and the write is dropped, because acceptance is evaluated on the pre-edge flags.
REQ-022 When empty, read and write together: the write is accepted and the read is dropped.
REQ-023 enable=0: no reads, writes or pointer/count changes; data_out holds its value.
REQ-024 Data leaves the FIFO in write order (first in, first out).

Reset
REQ-025 reset=0 asynchronously forces wr_ptr=0, rd_ptr=0, count=0, data_out=0, so that empty=1 and full=0; memory contents are not reset.
REQ-026 Reset asserted mid-operation discards all stored data; after reset is released, the first accepted write goes to address 0.
REQ-027 Operation resumes on the first rising edge after reset is released.

Configuration
REQ-028 Macro FIFO_RTL_ERR_FLAGS_EN controls the error-flag feature.
REQ-029 Without the macro: only the ports of REQ-003..REQ-011 exist.
REQ-030 With the macro: outputs overflow and underflow (1 bit each) are added; overflow is set by a write attempt while full, underflow by a read attempt while empty (enable=1 in both cases).
REQ-031 overflow and underflow are sticky and are cleared only by reset.

Verification
REQ-032 Reset, then enable=1 with no requests -> empty=1, full=0, data_out=0x00.
REQ-033 Write 64 bytes 0x00..0x3F with read_en=0 -> full=1 after the 64th edge; a 65th write of 0xAA is dropped (count stays 64, overflow=1 if compiled in).
REQ-034 From full, read 64 times -> data_out sequence 0x00..0x3F, each value 1 cycle after its read edge; empty=1 after the last read; an extra read leaves data_out=0x3F (underflow=1 if compiled in).
REQ-035 Continuous read+write at half occupancy for 200 cycles -> count constant; output stream equals input stream delayed by the occupancy; pointers wrap cleanly.
REQ-036 Drop enable to 0 for 4 cycles while write_en=read_en=1 -> pointers, count, flags and data_out frozen; operation resumes when enable returns to 1.
REQ-037 Assert reset with 10 words stored -> empty=1 and data_out=0 immediately, without waiting for a clock edge; the next write/read pair returns the newly written word.
